// File: rtl/mem_vpi_pkg.sv
// Shared definitions for the memory request scheduler: width helpers,
// outstanding-slot entry layout and read/write encoding.
package mem_vpi_pkg;

    // Slot fields are sized for the widest supported configuration
    // (16 channels, 32-bit transaction ids); narrower builds zero-extend.
    localparam int SLOT_CH_W  = 4;
    localparam int SLOT_TID_W = 32;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef struct packed {
        logic                  busy;
        logic [SLOT_CH_W-1:0]  ch;
        logic [SLOT_TID_W-1:0] tid;
    } slot_t;

    function automatic int log2_ceil(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r = r + 1;
        end
        return r;
    endfunction

    function automatic int ch_width(input int n);
        return (log2_ceil(n) < 1) ? 1 : log2_ceil(n);
    endfunction

    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the winner when the grant is consumed.
module rr_arbiter
    import mem_vpi_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = ch_width(N);

    logic [PW-1:0] ptr_q, ptr_d;

    // Wrap-around search from the pointer; next pointer is winner + 1
    always_comb begin
        int j;
        grant = '0;
        ptr_d = ptr_q;
        j     = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            if (req[PW'(j)] && (grant == '0)) begin
                grant[PW'(j)] = 1'b1;
                if (advance) ptr_d = (j == N - 1) ? '0 : PW'(j + 1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_req_scheduler.sv
// Multi-channel memory request scheduler: pops request FIFOs round-robin,
// tags each request with a free outstanding slot, and routes tagged
// responses back to the originating channel's response FIFO.
module mem_req_scheduler
    import mem_vpi_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 31,
    parameter int TID_WIDTH  = 16,
    parameter int MAX_OUT    = 8,
    localparam int REQ_WIDTH      = req_width(ADDR_WIDTH, DATA_WIDTH),
    localparam int DP_DATA_WIDTH  = TID_WIDTH + REQ_WIDTH,
    localparam int VPI_DATA_WIDTH = TID_WIDTH + DATA_WIDTH,
    localparam int TAG_WIDTH      = log2_ceil(MAX_OUT)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CH*DP_DATA_WIDTH-1:0]  incoming_data,
    input  logic [NUM_CH-1:0]                empty_signal,
    output logic [NUM_CH-1:0]                read_ctr,
    output logic [NUM_CH*VPI_DATA_WIDTH-1:0] outgoing_data,
    input  logic [NUM_CH-1:0]                full_signal,
    output logic [NUM_CH-1:0]                write_ctr,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic                             mem_req_rw,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr,
    output logic [DATA_WIDTH-1:0]            mem_req_data,
    output logic [TAG_WIDTH-1:0]             mem_req_tag,
    input  logic                             mem_rsp_valid,
    output logic                             mem_rsp_ready,
    input  logic [TAG_WIDTH-1:0]             mem_rsp_tag,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data,
    output logic [TAG_WIDTH:0]               outstanding,
    output logic                             tag_error
);

    localparam logic [TAG_WIDTH:0] OUT_ONE = (TAG_WIDTH + 1)'(1);

    slot_t slot_q [MAX_OUT];
    slot_t slot_d [MAX_OUT];

    logic                             req_valid_q, req_valid_d;
    logic                             req_rw_q, req_rw_d;
    logic [ADDR_WIDTH-1:0]            req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0]            req_data_q, req_data_d;
    logic [TAG_WIDTH-1:0]             req_tag_q, req_tag_d;
    logic [NUM_CH-1:0]                write_ctr_q, write_ctr_d;
    logic [NUM_CH*VPI_DATA_WIDTH-1:0] outgoing_q, outgoing_d;
    logic [TAG_WIDTH:0]               outstanding_q, outstanding_d;
    logic                             tag_error_q, tag_error_d;

    logic [NUM_CH-1:0]        grant;
    logic                     issue;
    logic                     free_found;
    logic [TAG_WIDTH-1:0]     free_idx;
    logic [DP_DATA_WIDTH-1:0] sel_req;
    logic [SLOT_CH_W-1:0]     sel_ch;
    slot_t                    rsp_slot;
    logic                     rsp_full;
    logic                     rsp_fire;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (~empty_signal),
        .advance (issue),
        .grant   (grant)
    );

    // Lowest-index free slot (descending scan so the lowest wins)
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_OUT - 1; i >= 0; i--) begin
            if (!slot_q[i].busy) begin
                free_found = 1'b1;
                free_idx   = TAG_WIDTH'(i);
            end
        end
    end

    // Head entry and index of the granted channel
    always_comb begin
        sel_req = '0;
        sel_ch  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant[c]) begin
                sel_req = incoming_data[c*DP_DATA_WIDTH +: DP_DATA_WIDTH];
                sel_ch  = SLOT_CH_W'(c);
            end
        end
    end

    assign issue = !reset && (|(~empty_signal)) && free_found &&
                   (!req_valid_q || mem_req_ready);
    assign read_ctr = issue ? grant : '0;

    assign rsp_slot = slot_q[mem_rsp_tag];

    // Full flag of the channel owning the addressed slot
    always_comb begin
        rsp_full = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rsp_slot.ch == SLOT_CH_W'(c)) rsp_full = full_signal[c];
        end
    end

    // Stray tags are always accepted so they can be dropped and flagged
    assign mem_rsp_ready = !rsp_slot.busy || !rsp_full;
    assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;

    // Next state: response retires a slot, issue allocates one
    always_comb begin
        slot_d        = slot_q;
        req_valid_d   = req_valid_q;
        req_rw_d      = req_rw_q;
        req_addr_d    = req_addr_q;
        req_data_d    = req_data_q;
        req_tag_d     = req_tag_q;
        write_ctr_d   = '0;
        outgoing_d    = outgoing_q;
        outstanding_d = outstanding_q;
        tag_error_d   = tag_error_q;

        if (rsp_fire) begin
            if (rsp_slot.busy) begin
                slot_d[mem_rsp_tag].busy = 1'b0;
                outstanding_d = outstanding_d - OUT_ONE;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (rsp_slot.ch == SLOT_CH_W'(c)) begin
                        write_ctr_d[c] = 1'b1;
                        outgoing_d[c*VPI_DATA_WIDTH +: VPI_DATA_WIDTH] =
                            {TID_WIDTH'(rsp_slot.tid), mem_rsp_data};
                    end
                end
            end else begin
                tag_error_d = 1'b1;
            end
        end

        // The allocated slot was free in slot_q, so it never collides with
        // the slot retired above in the same cycle.
        if (issue) begin
            slot_d[free_idx] = '{busy: 1'b1,
                                 ch:   sel_ch,
                                 tid:  SLOT_TID_W'(sel_req[DP_DATA_WIDTH-1 -: TID_WIDTH])};
            outstanding_d = outstanding_d + OUT_ONE;
            req_valid_d   = 1'b1;
            req_rw_d      = sel_req[REQ_WIDTH-1] ? RW_READ : RW_WRITE;
            req_addr_d    = sel_req[DATA_WIDTH +: ADDR_WIDTH];
            req_data_d    = sel_req[DATA_WIDTH-1:0];
            req_tag_d     = free_idx;
        end else if (mem_req_ready) begin
            req_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MAX_OUT; i++) slot_q[i] <= '0;
            req_valid_q   <= 1'b0;
            req_rw_q      <= 1'b0;
            req_addr_q    <= '0;
            req_data_q    <= '0;
            req_tag_q     <= '0;
            write_ctr_q   <= '0;
            outgoing_q    <= '0;
            outstanding_q <= '0;
            tag_error_q   <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_OUT; i++) slot_q[i] <= slot_d[i];
            req_valid_q   <= req_valid_d;
            req_rw_q      <= req_rw_d;
            req_addr_q    <= req_addr_d;
            req_data_q    <= req_data_d;
            req_tag_q     <= req_tag_d;
            write_ctr_q   <= write_ctr_d;
            outgoing_q    <= outgoing_d;
            outstanding_q <= outstanding_d;
            tag_error_q   <= tag_error_d;
        end
    end

    assign mem_req_valid = req_valid_q;
    assign mem_req_rw    = req_rw_q;
    assign mem_req_addr  = req_addr_q;
    assign mem_req_data  = req_data_q;
    assign mem_req_tag   = req_tag_q;
    assign write_ctr     = write_ctr_q;
    assign outgoing_data = outgoing_q;
    assign outstanding   = outstanding_q;
    assign tag_error     = tag_error_q;

endmodule

// File: tb/tb_mem_req_scheduler.sv
// Testbench for mem_req_scheduler: request FIFOs and the memory side are
// emulated here; a transaction-level model predicts every output.
module tb_mem_req_scheduler;

    localparam int NUM_CH = 4;
    localparam int MO     = 8;
    localparam int DP     = 80;
    localparam int VPI    = 48;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic [NUM_CH*DP-1:0]  incoming_data = '0;
    logic [NUM_CH-1:0]     empty_signal = '1;
    logic [NUM_CH-1:0]     read_ctr;
    logic [NUM_CH*VPI-1:0] outgoing_data;
    logic [NUM_CH-1:0]     full_signal = '0;
    logic [NUM_CH-1:0]     write_ctr;
    logic                  mem_req_valid;
    logic                  mem_req_ready = 1'b1;
    logic                  mem_req_rw;
    logic [30:0]           mem_req_addr;
    logic [31:0]           mem_req_data;
    logic [2:0]            mem_req_tag;
    logic                  mem_rsp_valid = 1'b0;
    logic                  mem_rsp_ready;
    logic [2:0]            mem_rsp_tag = '0;
    logic [31:0]           mem_rsp_data = '0;
    logic [3:0]            outstanding;
    logic                  tag_error;

    mem_req_scheduler dut (
        .clk           (clk),
        .reset         (reset),
        .incoming_data (incoming_data),
        .empty_signal  (empty_signal),
        .read_ctr      (read_ctr),
        .outgoing_data (outgoing_data),
        .full_signal   (full_signal),
        .write_ctr     (write_ctr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_rw    (mem_req_rw),
        .mem_req_addr  (mem_req_addr),
        .mem_req_data  (mem_req_data),
        .mem_req_tag   (mem_req_tag),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_tag   (mem_rsp_tag),
        .mem_rsp_data  (mem_rsp_data),
        .outstanding   (outstanding),
        .tag_error     (tag_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // emulated request FIFOs
    logic [DP-1:0] fifo_mem [NUM_CH][256];
    int            fifo_rd [NUM_CH];
    int            fifo_wr [NUM_CH];

    // reference model
    logic          m_busy [MO];
    int            m_ch   [MO];
    logic [15:0]   m_tid  [MO];
    int            m_last;
    logic          m_req_valid;
    logic          m_req_rw;
    logic [30:0]   m_req_addr;
    logic [31:0]   m_req_data;
    int            m_req_tag;
    logic [3:0]    m_write_ctr;
    logic [VPI-1:0] m_out [NUM_CH];
    logic          m_tag_error;
    logic          m_accept;

    logic [3:0]    exp_read_ctr, obs_read_ctr;
    logic          exp_rsp_ready, obs_rsp_ready;
    int            pops;

    // handshaken requests awaiting a response
    int            acc_tag [$];
    logic [31:0]   acc_data [$];
    logic          acc_rw [$];

    task automatic drive_fifos();
        for (int c = 0; c < NUM_CH; c++) begin
            empty_signal[c] = (fifo_rd[c] == fifo_wr[c]);
            incoming_data[c*DP +: DP] = empty_signal[c] ? '0 : fifo_mem[c][fifo_rd[c] % 256];
        end
    endtask

    task automatic clear_fifos();
        for (int c = 0; c < NUM_CH; c++) begin
            fifo_rd[c] = 0;
            fifo_wr[c] = 0;
        end
        drive_fifos();
    endtask

    task automatic push_req(input int c, input logic [15:0] tid, input logic rw,
                            input logic [30:0] addr, input logic [31:0] data);
        fifo_mem[c][fifo_wr[c] % 256] = {tid, rw, addr, data};
        fifo_wr[c] = fifo_wr[c] + 1;
        drive_fifos();
    endtask

    task automatic model_clear();
        for (int s = 0; s < MO; s++) begin
            m_busy[s] = 1'b0;
            m_ch[s]   = 0;
            m_tid[s]  = '0;
        end
        for (int c = 0; c < NUM_CH; c++) m_out[c] = '0;
        m_last      = NUM_CH - 1;
        m_req_valid = 1'b0;
        m_write_ctr = '0;
        m_tag_error = 1'b0;
        acc_tag.delete();
        acc_data.delete();
        acc_rw.delete();
    endtask

    function automatic int model_count();
        int n;
        n = 0;
        for (int s = 0; s < MO; s++) if (m_busy[s]) n++;
        return n;
    endfunction

    function automatic logic [NUM_CH*VPI-1:0] model_out();
        logic [NUM_CH*VPI-1:0] v;
        for (int c = 0; c < NUM_CH; c++) v[c*VPI +: VPI] = m_out[c];
        return v;
    endfunction

    // One clock: predict/observe combinational outputs mid-cycle, then
    // advance the model across the edge. Returns at posedge + 1.
    task automatic tick();
        int g, t, c;
        logic iss, hs;
        logic [DP-1:0] e;
        @(negedge clk);
        g = -1;
        for (int k = 1; k <= NUM_CH; k++) begin
            c = (m_last + k) % NUM_CH;
            if (g < 0 && fifo_rd[c] != fifo_wr[c]) g = c;
        end
        t = -1;
        for (int s = MO - 1; s >= 0; s--) if (!m_busy[s]) t = s;
        iss = !reset && (g >= 0) && (t >= 0) && (!m_req_valid || mem_req_ready);
        exp_read_ctr  = iss ? 4'(1 << g) : 4'b0;
        exp_rsp_ready = !m_busy[mem_rsp_tag] || !full_signal[m_ch[mem_rsp_tag]];
        obs_read_ctr  = read_ctr;
        obs_rsp_ready = mem_rsp_ready;
        m_accept = mem_rsp_valid && exp_rsp_ready && !reset;
        hs       = m_req_valid && mem_req_ready && !reset;
        @(posedge clk);
        #1;
        if (reset) begin
            model_clear();
        end else begin
            if (hs) begin
                acc_tag.push_back(m_req_tag);
                acc_data.push_back(m_req_data);
                acc_rw.push_back(m_req_rw);
            end
            m_write_ctr = '0;
            if (m_accept) begin
                if (m_busy[mem_rsp_tag]) begin
                    m_busy[mem_rsp_tag] = 1'b0;
                    m_write_ctr[m_ch[mem_rsp_tag]] = 1'b1;
                    m_out[m_ch[mem_rsp_tag]] = {m_tid[mem_rsp_tag], mem_rsp_data};
                end else begin
                    m_tag_error = 1'b1;
                end
            end
            if (iss) begin
                e = fifo_mem[g][fifo_rd[g] % 256];
                fifo_rd[g] = fifo_rd[g] + 1;
                m_busy[t]   = 1'b1;
                m_ch[t]     = g;
                m_tid[t]    = e[79:64];
                m_req_valid = 1'b1;
                m_req_rw    = e[63];
                m_req_addr  = e[62:32];
                m_req_data  = e[31:0];
                m_req_tag   = t;
                m_last      = g;
                pops++;
            end else if (mem_req_ready) begin
                m_req_valid = 1'b0;
            end
        end
        drive_fifos();
    endtask

    task automatic do_reset();
        clear_fifos();
        reset = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        full_signal = '0;
        tick();
        tick();
        reset = 1'b0;
        pops = 0;
    endtask

    task automatic test_reset();
        clear_fifos();
        reset = 1'b1;
        mem_req_ready = 1'b0;
        tick();
        tick();
        n_checks++;
        if (obs_read_ctr !== 4'b0) begin n_fail++; $display("FAIL reset_read_ctr: got %b expected 0000", obs_read_ctr); end
        reset = 1'b0;
        n_checks++;
        if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", mem_req_valid); end
        n_checks++;
        if (outstanding !== 4'd0) begin n_fail++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        n_checks++;
        if (tag_error !== 1'b0) begin n_fail++; $display("FAIL reset_tag_error: got %b expected 0", tag_error); end
        n_checks++;
        if (write_ctr !== 4'b0) begin n_fail++; $display("FAIL reset_write_ctr: got %b expected 0000", write_ctr); end
        n_checks++;
        if (outgoing_data !== '0) begin n_fail++; $display("FAIL reset_outgoing: got %h expected 0", outgoing_data); end
        tick();
        n_checks++;
        if (obs_read_ctr !== 4'b0) begin n_fail++; $display("FAIL idle_read_ctr: got %b expected 0000", obs_read_ctr); end
    endtask

    task automatic test_rr_pattern();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_req(1, 16'(i), 1'b1, 31'(100 + i), 32'(i));
            push_req(3, 16'(i), 1'b0, 31'(200 + i), 32'(i));
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (obs_read_ctr !== ((k % 2 == 0) ? 4'b0010 : 4'b1000)) begin
                n_fail++; $display("FAIL rr_grant k=%0d: got %b", k, obs_read_ctr);
            end
            n_checks++;
            if (mem_req_valid !== 1'b1 || mem_req_tag !== 3'(k)) begin
                n_fail++; $display("FAIL rr_tag k=%0d: got v=%b tag=%0d expected v=1 tag=%0d", k, mem_req_valid, mem_req_tag, k);
            end
        end
        tick();
        n_checks++;
        if (obs_read_ctr !== 4'b0) begin n_fail++; $display("FAIL rr_full_stop: got %b expected 0000", obs_read_ctr); end
    endtask

    task automatic test_table_full();
        logic [3:0] last_rc;
        do_reset();
        for (int i = 0; i < 10; i++) push_req(0, 16'(i), 1'b1, 31'(i), 32'(i));
        for (int k = 0; k < 12; k++) begin
            tick();
            last_rc = obs_read_ctr;
        end
        n_checks++;
        if (pops !== 8) begin n_fail++; $display("FAIL full_pops: got %0d expected 8", pops); end
        n_checks++;
        if (outstanding !== 4'd8) begin n_fail++; $display("FAIL full_outstanding: got %0d expected 8", outstanding); end
        n_checks++;
        if (last_rc !== 4'b0) begin n_fail++; $display("FAIL full_read_ctr: got %b expected 0000", last_rc); end
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 3'd0;
        mem_rsp_data  = 32'hCAFE_0000;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++;
        if (obs_read_ctr !== 4'b0) begin n_fail++; $display("FAIL full_same_cycle: got %b expected 0000", obs_read_ctr); end
        n_checks++;
        if (write_ctr !== 4'b0001) begin n_fail++; $display("FAIL full_rsp_write: got %b expected 0001", write_ctr); end
        tick();
        n_checks++;
        if (obs_read_ctr !== 4'b0001) begin n_fail++; $display("FAIL full_refill: got %b expected 0001", obs_read_ctr); end
        tick();
        tick();
        n_checks++;
        if (pops !== 9 || outstanding !== 4'd8) begin
            n_fail++; $display("FAIL full_after: got pops=%0d out=%0d expected 9/8", pops, outstanding);
        end
    endtask

    task automatic test_full_backpressure();
        do_reset();
        push_req(2, 16'h0001, 1'b1, 31'h10, 32'h0);
        push_req(2, 16'h0002, 1'b1, 31'h11, 32'h0);
        push_req(2, 16'h0003, 1'b0, 31'h12, 32'h5);
        push_req(2, 16'h00A5, 1'b1, 31'h13, 32'h0);
        for (int k = 0; k < 5; k++) tick();
        full_signal   = 4'b0100;
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 3'd3;
        mem_rsp_data  = 32'h0000_1234;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (obs_rsp_ready !== 1'b0 || write_ctr !== 4'b0) begin
                n_fail++; $display("FAIL bp_hold k=%0d: got ready=%b wr=%b expected 0/0000", k, obs_rsp_ready, write_ctr);
            end
        end
        full_signal = 4'b0000;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++;
        if (obs_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", obs_rsp_ready); end
        n_checks++;
        if (write_ctr !== 4'b0100) begin n_fail++; $display("FAIL bp_write_ctr: got %b expected 0100", write_ctr); end
        n_checks++;
        if (outgoing_data[2*VPI +: VPI] !== {16'h00A5, 32'h0000_1234}) begin
            n_fail++; $display("FAIL bp_outgoing: got %h expected 00a500001234", outgoing_data[2*VPI +: VPI]);
        end
        tick();
        n_checks++;
        if (write_ctr !== 4'b0 || outgoing_data[2*VPI +: VPI] !== {16'h00A5, 32'h0000_1234}) begin
            n_fail++; $display("FAIL bp_hold_after: got wr=%b out=%h", write_ctr, outgoing_data[2*VPI +: VPI]);
        end
    endtask

    task automatic test_free_tag();
        do_reset();
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 3'd5;
        mem_rsp_data  = 32'h1111_2222;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++;
        if (obs_rsp_ready !== 1'b1) begin n_fail++; $display("FAIL free_ready: got %b expected 1", obs_rsp_ready); end
        n_checks++;
        if (write_ctr !== 4'b0 || tag_error !== 1'b1) begin
            n_fail++; $display("FAIL free_drop: got wr=%b err=%b expected 0000/1", write_ctr, tag_error);
        end
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if (tag_error !== 1'b1) begin n_fail++; $display("FAIL free_sticky: got %b expected 1", tag_error); end
        do_reset();
        n_checks++;
        if (tag_error !== 1'b0) begin n_fail++; $display("FAIL free_clear: got %b expected 0", tag_error); end
    endtask

    task automatic test_ready_stall();
        do_reset();
        mem_req_ready = 1'b0;
        push_req(0, 16'h0A, 1'b0, 31'h0000_0AAA, 32'hDEAD_BEEF);
        push_req(0, 16'h0B, 1'b1, 31'h0000_0BBB, 32'h0000_0B0B);
        push_req(0, 16'h0C, 1'b1, 31'h0000_0CCC, 32'h0000_0C0C);
        tick();
        n_checks++;
        if (obs_read_ctr !== 4'b0001) begin n_fail++; $display("FAIL stall_first_pop: got %b expected 0001", obs_read_ctr); end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (obs_read_ctr !== 4'b0 || mem_req_valid !== 1'b1 || mem_req_tag !== 3'd0 ||
                mem_req_data !== 32'hDEAD_BEEF || mem_req_addr !== 31'h0000_0AAA || mem_req_rw !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold k=%0d: got rc=%b v=%b tag=%0d data=%h addr=%h rw=%b",
                                   k, obs_read_ctr, mem_req_valid, mem_req_tag, mem_req_data, mem_req_addr, mem_req_rw);
            end
        end
        mem_req_ready = 1'b1;
        tick();
        n_checks++;
        if (obs_read_ctr !== 4'b0001) begin n_fail++; $display("FAIL stall_release_pop: got %b expected 0001", obs_read_ctr); end
        n_checks++;
        if (mem_req_valid !== 1'b1 || mem_req_tag !== 3'd1 || mem_req_data !== 32'h0000_0B0B || mem_req_rw !== 1'b1) begin
            n_fail++; $display("FAIL stall_next_req: got v=%b tag=%0d data=%h rw=%b expected 1/1/00000b0b/1",
                               mem_req_valid, mem_req_tag, mem_req_data, mem_req_rw);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] tags_seen;
        do_reset();
        for (int i = 0; i < 6; i++) push_req(0, 16'(i), 1'b1, 31'(i), 32'(i));
        for (int k = 0; k < 7; k++) tick();
        n_checks++;
        if (outstanding !== 4'd6) begin n_fail++; $display("FAIL mid_pre: got %0d expected 6", outstanding); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (outstanding !== 4'd0 || mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got out=%0d v=%b expected 0/0", outstanding, mem_req_valid);
        end
        mem_rsp_valid = 1'b1;
        mem_rsp_tag   = 3'd2;
        tick();
        mem_rsp_valid = 1'b0;
        n_checks++;
        if (tag_error !== 1'b1 || write_ctr !== 4'b0) begin
            n_fail++; $display("FAIL mid_stale_rsp: got err=%b wr=%b expected 1/0000", tag_error, write_ctr);
        end
        pops = 0;
        tags_seen = '0;
        for (int i = 0; i < 9; i++) push_req(1, 16'(i), 1'b0, 31'(i), 32'(i));
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mem_req_valid === 1'b1) tags_seen[mem_req_tag] = 1'b1;
        end
        n_checks++;
        if (pops !== 8 || outstanding !== 4'd8 || tags_seen !== 8'hFF) begin
            n_fail++; $display("FAIL mid_realloc: got pops=%0d out=%0d tags=%h expected 8/8/ff", pops, outstanding, tags_seen);
        end
    endtask

    task automatic test_random();
        int idx;
        do_reset();
        for (int cyc = 0; cyc < 500; cyc++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 2) == 0 && (fifo_wr[c] - fifo_rd[c]) < 16)
                    push_req(c, 16'($urandom), 1'($urandom), 31'($urandom), $urandom);
            end
            mem_req_ready = ($urandom_range(0, 3) != 0);
            full_signal   = 4'($urandom) & 4'($urandom);
            if (!mem_rsp_valid && acc_tag.size() > 0 && $urandom_range(0, 2) != 0) begin
                idx = $urandom_range(0, acc_tag.size() - 1);
                mem_rsp_tag   = 3'(acc_tag[idx]);
                mem_rsp_data  = acc_rw[idx] ? $urandom : acc_data[idx];
                mem_rsp_valid = 1'b1;
                acc_tag.delete(idx);
                acc_data.delete(idx);
                acc_rw.delete(idx);
            end
            reset = ($urandom_range(0, 199) == 0);
            if (reset) mem_rsp_valid = 1'b0;
            tick();
            if (m_accept) mem_rsp_valid = 1'b0;
            n_checks++;
            if (obs_read_ctr !== exp_read_ctr) begin n_fail++; $display("FAIL rnd_read_ctr c=%0d: got %b expected %b", cyc, obs_read_ctr, exp_read_ctr); end
            n_checks++;
            if (obs_rsp_ready !== exp_rsp_ready) begin n_fail++; $display("FAIL rnd_rsp_ready c=%0d: got %b expected %b", cyc, obs_rsp_ready, exp_rsp_ready); end
            n_checks++;
            if (mem_req_valid !== m_req_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b expected %b", cyc, mem_req_valid, m_req_valid); end
            if (m_req_valid) begin
                n_checks++;
                if (mem_req_rw !== m_req_rw || mem_req_addr !== m_req_addr ||
                    mem_req_data !== m_req_data || mem_req_tag !== 3'(m_req_tag)) begin
                    n_fail++; $display("FAIL rnd_payload c=%0d: got %b/%h/%h/%0d expected %b/%h/%h/%0d", cyc,
                                       mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
                                       m_req_rw, m_req_addr, m_req_data, m_req_tag);
                end
            end
            n_checks++;
            if (write_ctr !== m_write_ctr) begin n_fail++; $display("FAIL rnd_write_ctr c=%0d: got %b expected %b", cyc, write_ctr, m_write_ctr); end
            n_checks++;
            if (outgoing_data !== model_out()) begin n_fail++; $display("FAIL rnd_outgoing c=%0d: got %h expected %h", cyc, outgoing_data, model_out()); end
            n_checks++;
            if (outstanding !== 4'(model_count())) begin n_fail++; $display("FAIL rnd_outstanding c=%0d: got %0d expected %0d", cyc, outstanding, model_count()); end
            n_checks++;
            if (tag_error !== m_tag_error) begin n_fail++; $display("FAIL rnd_tag_error c=%0d: got %b expected %b", cyc, tag_error, m_tag_error); end
        end
        reset = 1'b0;
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pops = 0;
        model_clear();
        clear_fifos();
        test_reset();
        test_rr_pattern();
        test_table_full();
        test_full_backpressure();
        test_free_tag();
        test_ready_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
